example_mul_share_arb: RTL

EXAMPLE_MUL_SHARE_ARB -- requirements
Module: example_mul_share_arb

---
 rtl/example_mul_share_arb.sv | 86 ++++++++
 1 files changed

// File: rtl/example_mul_share_arb.sv
// example_mul_share_arb: round-robin arbiter feeding one shared two-stage signed multiplier.
// Stage 1 latches the granted operands; stage 2 holds the product until downstream accepts it.
module example_mul_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 7,
    parameter int B_WIDTH  = 14,
    parameter int P_WIDTH  = A_WIDTH + B_WIDTH,
    parameter int ID_WIDTH = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [P_WIDTH-1:0]    rsp_p,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         busy
);
    logic [ID_WIDTH-1:0]        ptr_q, ptr_d, gnt_id;
    logic                       gnt_any, en, take;
    logic                       s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic signed [A_WIDTH-1:0]  s1_a_q, s1_a_d;
    logic signed [B_WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [ID_WIDTH-1:0]        s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic signed [P_WIDTH-1:0]  a_ext, b_ext, s2_p_q, s2_p_d;

    assign en = !s2_v_q || rsp_ready;

    // Scan downward so the smallest offset from ptr_q is the one that sticks.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_id  = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
                gnt_any = 1'b1;
            end
        end
    end

    assign req_ready = (gnt_any && en && ap_rst_n) ? NUM_REQ'(1) << gnt_id : '0;
    assign take      = |req_ready;
    assign a_ext     = P_WIDTH'(s1_a_q);
    assign b_ext     = P_WIDTH'(s1_b_q);

    always_comb begin
        ptr_d   = take ? ((int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
        s1_v_d  = en ? take : s1_v_q;
        s1_a_d  = en ? req_a[gnt_id*A_WIDTH +: A_WIDTH] : s1_a_q;
        s1_b_d  = en ? req_b[gnt_id*B_WIDTH +: B_WIDTH] : s1_b_q;
        s1_id_d = en ? gnt_id : s1_id_q;
        s2_v_d  = en ? s1_v_q : s2_v_q;
        s2_p_d  = en ? a_ext * b_ext : s2_p_q;
        s2_id_d = en ? s1_id_q : s2_id_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_p_q  <= '0;
            s2_id_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_p_q  <= s2_p_d;
            s2_id_q <= s2_id_d;
        end
    end

    assign rsp_valid = s2_v_q;
    assign rsp_p     = s2_p_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_v_q || s2_v_q;
endmodule
